let_op_unit: RTL and testbench
==============================

LET_OP_UNIT -- requirements
Module: let_op_unit

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal range 1..32).
REQ-002 Parameter CNT_W, default 8, width of the hit counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand set present this cycle.
REQ-006 x  input  WIDTH  first OR operand.
REQ-007 y  input  WIDTH  second OR operand.
REQ-008 z  input  WIDTH  AND mask.
REQ-009 clr  input  1  synchronous clear of hit_count.
REQ-010 out_valid  output  1  result registers updated from a valid operand set.
REQ-011 d  output  1  reduction result |((x|y)&z).
REQ-012 masked  output  WIDTH  vector (x|y)&z.
REQ-013 hit_count  output  CNT_W  saturating count of accepted sets with d=1.

Function
REQ-014 On a rising clk edge with in_valid=1, the block SHALL register masked <= (x|y)&z and d <= OR-reduction of that vector.
REQ-015 Latency SHALL be exactly one cycle: out_valid=1 in the cycle after in_valid=1, else 0.
REQ-016 With in_valid=0, d and masked SHALL hold their previous values; only out_valid drops to 0.
REQ-017 No backpressure: every in_valid=1 cycle is accepted; back-to-back valid cycles SHALL produce back-to-back results.
REQ-018 All operations SHALL be bitwise on WIDTH bits; no sign extension, no carries.
REQ-019 hit_count SHALL increment by 1 on each accepted set whose computed d is 1.
REQ-020 hit_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-021 clr=1 SHALL set hit_count to 0 on the next edge, taking priority over a simultaneous increment.
REQ-022 clr SHALL NOT affect d, masked or out_valid.
REQ-023 d SHALL equal 1 iff at least one bit position has z=1 and (x=1 or y=1).

Reset
REQ-024 While rst=1, out_valid, d, masked and hit_count SHALL be 0 immediately, without waiting for clk.
REQ-025 An operand set presented in the same cycle rst deasserts SHALL be accepted on the next rising edge after deassertion.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; out_valid SHALL be 0 in the first cycle after reset releases unless in_valid was 1.

Verification
REQ-027 x=12, y=15, z=7, in_valid=1 -> next cycle out_valid=1, masked=4'b0111, d=1, hit_count=1.
REQ-028 x=8, y=0, z=7 -> masked=0, d=0, hit_count unchanged.
REQ-029 x=0, y=0, z=15 -> d=0; then in_valid=0 for 3 cycles -> d and masked hold, out_valid=0.
REQ-030 CNT_W=2, five consecutive sets with d=1 -> hit_count reads 1,2,3,3,3.
REQ-031 clr=1 together with a d=1 set -> hit_count=0, d=1, out_valid=1.
REQ-032 Assert rst asynchronously between edges after REQ-027 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/let_op_unit.sv
// Registered bitwise (x|y)&z unit with OR-reduction flag and a saturating hit counter.
// Each operand bit is handled by its own lane; the lanes share a single valid pipe.

module let_op_lane (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic m
);
  assign m = (x | y) & z;
endmodule

module let_op_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             clr,
  output logic             out_valid,
  output logic             d,
  output logic [WIDTH-1:0] masked,
  output logic [CNT_W-1:0] hit_count
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } req_t;

  req_t             req;
  logic [WIDTH-1:0] masked_c;
  logic             d_c;
  logic [STAGES:0]  vld_pipe;

  assign req = '{x: x, y: y, z: z};

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      let_op_lane u_lane (
        .x (req.x[i]),
        .y (req.y[i]),
        .z (req.z[i]),
        .m (masked_c[i])
      );
    end
  endgenerate

  assign d_c         = |masked_c;
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Result registers only load on accepted sets; idle cycles hold the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      masked <= '0;
      d      <= 1'b0;
    end else if (in_valid) begin
      masked <= masked_c;
      d      <= d_c;
    end
  end

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_count <= '0;
    else if (clr)
      hit_count <= '0;
    else if (in_valid && d_c && (hit_count != {CNT_W{1'b1}}))
      hit_count <= hit_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_let_op_unit.sv
// Self-checking bench for let_op_unit: directed vector table, corner sequences,
// then randomized traffic against a bit-level reference model.

module tb_let_op_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] x, y, z;
  logic       clr;

  logic       ov1, d1;
  logic [3:0] m1;
  logic [7:0] c1;
  logic       ov2, d2;
  logic [3:0] m2;
  logic [1:0] c2;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic       ov_e, d_e;
  logic [3:0] m_e;
  int         c1_e, c2_e;

  typedef struct {
    logic [3:0] x, y, z;
    logic       v, clr;
    logic       ov, d;
    logic [3:0] m;
    int         cnt;
  } vec_t;

  vec_t vecs [11];
  int   sat_exp [5];

  let_op_unit #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .z(z), .clr(clr),
    .out_valid(ov1), .d(d1), .masked(m1), .hit_count(c1)
  );

  let_op_unit #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .z(z), .clr(clr),
    .out_valid(ov2), .d(d2), .masked(m2), .hit_count(c2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ov_e = 1'b0; d_e = 1'b0; m_e = '0; c1_e = 0; c2_e = 0;
  endtask

  // d is 1 iff some bit position has z set and x or y set
  task automatic model_edge();
    int hit;
    if (rst) return;
    ov_e = in_valid;
    if (in_valid) begin
      hit = 0;
      for (int b = 0; b < 4; b++) begin
        m_e[b] = z[b] && (x[b] || y[b]);
        if (m_e[b]) hit = 1;
      end
      d_e = (hit != 0);
      if (hit != 0) begin
        c1_e = (c1_e < 255) ? c1_e + 1 : 255;
        c2_e = (c2_e < 3)   ? c2_e + 1 : 3;
      end
    end
    if (clr) begin
      c1_e = 0; c2_e = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(ov1), 32'(ov_e));
    chk({tag, ".d"},         32'(d1),  32'(d_e));
    chk({tag, ".masked"},    32'(m1),  32'(m_e));
    chk({tag, ".hit_count"}, 32'(c1),  32'(c1_e));
    chk({tag, ".hit_count2"}, 32'(c2), 32'(c2_e));
    chk({tag, ".masked2"},   32'(m2),  32'(m_e));
    chk({tag, ".valid2_d2"}, 32'({ov2, d2}), 32'({ov_e, d_e}));
  endtask

  initial begin
    vecs[0]  = '{4'd12, 4'd15, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 1};
    vecs[1]  = '{4'd8,  4'd0,  4'd7,  1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1};
    vecs[2]  = '{4'd0,  4'd0,  4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1};
    vecs[3]  = '{4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vecs[4]  = '{4'd15, 4'd0,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vecs[5]  = '{4'd0,  4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vecs[6]  = '{4'd3,  4'd0,  4'd1,  1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 2};
    vecs[7]  = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 2};
    vecs[8]  = '{4'd5,  4'd0,  4'd4,  1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 0};
    vecs[9]  = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 0};
    vecs[10] = '{4'd0,  4'd9,  4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 1};
    sat_exp = '{1, 2, 3, 3, 3};

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0; clr = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    tick();
    rst = 1'b0;

    // directed table
    for (int k = 0; k < 11; k++) begin
      x = vecs[k].x; y = vecs[k].y; z = vecs[k].z;
      in_valid = vecs[k].v; clr = vecs[k].clr;
      tick();
      chk($sformatf("vec%0d.out_valid", k), 32'(ov1), 32'(vecs[k].ov));
      chk($sformatf("vec%0d.d", k),         32'(d1),  32'(vecs[k].d));
      chk($sformatf("vec%0d.masked", k),    32'(m1),  32'(vecs[k].m));
      chk($sformatf("vec%0d.hit_count", k), 32'(c1),  32'(vecs[k].cnt));
    end

    // saturation on the 2-bit counter
    in_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b1; x = 4'd1; y = 4'd0; z = 4'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("sat%0d.hit_count2", k), 32'(c2), 32'(sat_exp[k]));
      check_all($sformatf("sat%0d", k));
    end

    // asynchronous reset mid-stream, between edges
    x = 4'd12; y = 4'd15; z = 4'd7; in_valid = 1'b1;
    tick();
    check_all("pre_rst");
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_all("post_rst_idle");

    // operand set presented in the cycle reset releases
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0; in_valid = 1'b1; x = 4'd1; y = 4'd0; z = 4'd3;
    tick();
    chk("rel_accept.out_valid", 32'(ov1), 32'd1);
    chk("rel_accept.masked",    32'(m1),  32'd1);
    check_all("rel_accept");

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      x = 4'($urandom); y = 4'($urandom); z = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      tick();
      check_all($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
